// File: rtl/management_tx_fifo.sv
// Outbound frame buffer for the management Ethernet port: byte-wide frame assembly from the
// register interface, a committed-frame queue, and 32-bit word replay onto the mgmt0 TX bus.
module management_tx_fifo #(
    parameter int WORD_DEPTH  = 1024,
    parameter int FRAME_DEPTH = 32,
    parameter int MAX_LEN     = 1518
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [7:0]                     wr_data,
    input  logic                           wr_commit,
    input  logic                           wr_drop,
    input  logic                           tx_ready,
    output logic                           tx_start,
    output logic                           tx_data_valid,
    output logic [2:0]                     tx_bytes_valid,
    output logic [31:0]                    tx_data,
    output logic [$clog2(FRAME_DEPTH):0]   frames_pending,
    output logic [$clog2(WORD_DEPTH):0]    free_words,
    output logic                           overflow,
    output logic                           busy
);

    localparam int AW = $clog2(WORD_DEPTH);
    localparam int FW = $clog2(FRAME_DEPTH);
    localparam int LW = $clog2(MAX_LEN + 2);

    typedef enum logic [1:0] {IDLE, START, DATA} state_t;

    logic [31:0]   mem [WORD_DEPTH];
    logic [31:0]   ram_q;

    logic [LW-1:0] q_len [FRAME_DEPTH];
    logic [AW-1:0] q_ptr [FRAME_DEPTH];
    logic [FW-1:0] q_head;
    logic [FW-1:0] q_tail;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] commit_ptr;
    logic [AW-1:0] rd_head;
    logic [AW-1:0] rd_addr;
    logic [31:0]   wr_word;
    logic [1:0]    byte_pos;
    logic [LW-1:0] wr_len;
    logic          frame_bad;

    logic          byte_in;
    logic [31:0]   word_after;
    logic [1:0]    pos_after;
    logic [LW-1:0] len_after;
    logic          need_write;
    logic          ram_full;
    logic          do_write;
    logic          bad_after;
    logic [AW-1:0] ptr_after;
    logic          commit_req;
    logic          commit_ok;
    logic          commit_rej;

    state_t        state;
    state_t        state_next;
    logic          pop;
    logic          frame_done;
    logic          rd_en;
    logic [1:0]    cur_tail;
    logic [AW-1:0] cur_words;
    logic [AW-1:0] words_left;

    function automatic logic [AW-1:0] words_of(input logic [LW-1:0] len);
        return AW'(({1'b0, len} + (LW+1)'(3)) >> 2);
    endfunction

    always_comb begin
        byte_in    = wr_en && !wr_drop;
        word_after = wr_word;
        if (byte_in) begin
            case (byte_pos)
                2'd0:    word_after = {wr_data, 24'h0};
                2'd1:    word_after[23:16] = wr_data;
                2'd2:    word_after[15:8]  = wr_data;
                default: word_after[7:0]   = wr_data;
            endcase
        end
        pos_after  = byte_pos + {1'b0, byte_in};
        len_after  = (byte_in && wr_len != LW'(MAX_LEN + 1)) ? wr_len + LW'(1) : wr_len;
        // A full word is stored on its 4th byte; a partial word only when the frame is committed.
        need_write = (byte_in && byte_pos == 2'd3) ||
                     (wr_commit && !wr_drop && pos_after != 2'd0);
        ram_full   = (wr_ptr + AW'(1)) == rd_head;
        do_write   = need_write && !ram_full;
        bad_after  = frame_bad || (need_write && ram_full);
        ptr_after  = do_write ? wr_ptr + AW'(1) : wr_ptr;
        commit_req = wr_commit && !wr_drop && len_after != '0;
        commit_ok  = commit_req && !bad_after && len_after <= LW'(MAX_LEN) &&
                     frames_pending != (FW+1)'(FRAME_DEPTH);
        commit_rej = commit_req && !commit_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            wr_word    <= '0;
            byte_pos   <= '0;
            wr_len     <= '0;
            frame_bad  <= 1'b0;
            q_tail     <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= commit_rej;
            if (wr_drop) begin
                wr_ptr    <= commit_ptr;
                byte_pos  <= '0;
                wr_len    <= '0;
                frame_bad <= 1'b0;
            end else if (commit_req) begin
                if (commit_ok) begin
                    wr_ptr     <= ptr_after;
                    commit_ptr <= ptr_after;
                    q_tail     <= q_tail + FW'(1);
                end else begin
                    wr_ptr <= commit_ptr;
                end
                byte_pos  <= '0;
                wr_len    <= '0;
                frame_bad <= 1'b0;
            end else begin
                wr_word   <= word_after;
                byte_pos  <= pos_after;
                wr_len    <= len_after;
                frame_bad <= bad_after;
                wr_ptr    <= ptr_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit_ok) begin
            q_len[q_tail] <= len_after;
            q_ptr[q_tail] <= commit_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= word_after;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        frame_done     = 1'b0;
        rd_en          = 1'b0;
        tx_start       = 1'b0;
        tx_data_valid  = 1'b0;
        tx_bytes_valid = 3'd0;
        tx_data        = 32'h0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (frames_pending != '0 && tx_ready) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_start   = 1'b1;
                rd_en      = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                rd_en          = 1'b1;
                tx_data_valid  = 1'b1;
                tx_data        = ram_q;
                tx_bytes_valid = 3'd4;
                if (words_left == AW'(1)) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                    if (cur_tail != 2'd0)
                        tx_bytes_valid = {1'b0, cur_tail};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // rd_head only moves when a frame has fully left, so its words stay reserved while sending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            q_head         <= '0;
            rd_head        <= '0;
            rd_addr        <= '0;
            cur_tail       <= '0;
            cur_words      <= '0;
            words_left     <= '0;
            frames_pending <= '0;
            free_words     <= (AW+1)'(WORD_DEPTH);
        end else begin
            state <= state_next;
            if (pop) begin
                cur_tail   <= q_len[q_head][1:0];
                cur_words  <= words_of(q_len[q_head]);
                words_left <= words_of(q_len[q_head]);
                rd_addr    <= q_ptr[q_head];
                q_head     <= q_head + FW'(1);
            end else if (rd_en) begin
                rd_addr <= rd_addr + AW'(1);
            end
            if (state == DATA)
                words_left <= words_left - AW'(1);
            if (frame_done)
                rd_head <= rd_head + cur_words;
            case ({commit_ok, frame_done})
                2'b10:   frames_pending <= frames_pending + (FW+1)'(1);
                2'b01:   frames_pending <= frames_pending - (FW+1)'(1);
                default: frames_pending <= frames_pending;
            endcase
            free_words <= (AW+1)'(WORD_DEPTH) - {1'b0, wr_ptr - rd_head};
        end
    end

endmodule
